// File: rtl/inv_shift_rows_stream_if.sv
// Byte streams around the AES InvShiftRows stage: "s" side into the stage, "m" side out of it.
// With SHIFT_ROWS_FWD_MODE_EN defined the interface also carries fwd_mode.
// Handshake: a byte moves on a rising edge where valid && ready; once valid is
// raised with a byte, data and last hold until that transfer happens.
interface inv_shift_rows_stream_if #(
  parameter int BYTE_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [BYTE_W-1:0] m_data;
  logic              m_last;
`ifdef SHIFT_ROWS_FWD_MODE_EN
  logic              fwd_mode;

  modport slave (
    input  s_valid, s_data, m_ready, fwd_mode,
    output s_ready, m_valid, m_data, m_last
  );
  modport master (
    output s_valid, s_data, m_ready, fwd_mode,
    input  s_ready, m_valid, m_data, m_last
  );
`else
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
`endif
endinterface

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows with ping-pong block buffers (one fills while the other drains).
// Optional SHIFT_ROWS_FWD_MODE_EN adds a per-block forward ShiftRows mode.
module inv_shift_rows_stream #(
  parameter int BYTE_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  inv_shift_rows_stream_if.slave io
);

  logic [BYTE_W-1:0] mem [0:1][0:15];
  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [3:0]        wr_cnt;
  logic [3:0]        rd_cnt;
  logic              wr_en;
  logic              rd_en;
  logic              cur_fwd;
  logic [1:0]        row;
  logic [1:0]        col;
  logic [1:0]        src_col;
  logic [3:0]        rd_idx;

  assign io.s_ready = !rst && !full[wr_bank];
  assign io.m_valid = !rst && full[rd_bank];
  assign wr_en      = io.s_valid && io.s_ready;
  assign rd_en      = io.m_valid && io.m_ready;

`ifdef SHIFT_ROWS_FWD_MODE_EN
  logic [1:0] bank_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_mode <= 2'b00;
    end else if (wr_en && wr_cnt == 4'd0) begin
      bank_mode[wr_bank] <= io.fwd_mode;
    end
  end

  assign cur_fwd = bank_mode[rd_bank];
`else
  assign cur_fwd = 1'b0;
`endif

  // Byte k sits at row k[1:0], column k[3:2]; the output byte at (row, col)
  // comes from column col-row (inverse) or col+row (forward), modulo 4.
  assign row     = rd_cnt[1:0];
  assign col     = rd_cnt[3:2];
  assign src_col = cur_fwd ? (col + row) : (col - row);
  assign rd_idx  = {src_col, row};

  assign io.m_data = io.m_valid ? mem[rd_bank][rd_idx] : '0;
  assign io.m_last = io.m_valid && (rd_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_cnt] <= io.s_data;
    end
  end

  // Write completion and read completion always target opposite banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 4'd0;
      rd_cnt  <= 4'd0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_cnt == 4'd15) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_cnt == 4'd15) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed and randomized-stall bench for inv_shift_rows_stream.
// Define SHIFT_ROWS_FWD_MODE_EN for both files to include the forward-mode sequence.
module tb_inv_shift_rows_stream;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] din  [16];
    logic [W-1:0] dout [16];
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   ready_stall;
  logic [W:0] exp_q[$];
  logic       stall_prev;
  logic [W:0] hold_val;

  inv_shift_rows_stream_if #(.BYTE_W(W)) bus ();

  inv_shift_rows_stream #(.BYTE_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, required test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [W-1:0] d, input int stall, output int waits);
    logic hs;
    waits = 0;
    forever begin
      bus.s_valid = ($urandom_range(99) >= stall);
      bus.s_data  = d;
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      waits++;
      if (waits > 4000) begin
        check("push_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic expect_block(input logic [W-1:0] dout [16]);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), dout[k]});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // m_ready is re-randomised every cycle, after the data drivers have moved
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.m_ready = ($urandom_range(99) >= ready_stall);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", {23'd0, bus.m_valid, bus.m_last, bus.m_data}, {23'd0, 1'b1, hold_val});
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h, required no output", {bus.m_last, bus.m_data});
        end else begin
          check("out_byte", {23'd0, bus.m_last, bus.m_data}, {23'd0, exp_q.pop_front()});
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      hold_val   = {bus.m_last, bus.m_data};
    end
  end

  // ---------------- stimulus ----------------
  vec_t vecs [4];
  int   inv_tbl [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  initial begin
    int waits;
    int total_waits;
    logic [W-1:0] rdin [16];
    logic [W-1:0] rdout [16];

    n_checks    = 0;
    n_fail      = 0;
    ready_stall = 0;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
`ifdef SHIFT_ROWS_FWD_MODE_EN
    bus.fwd_mode = 1'b0;
`endif

    for (int k = 0; k < 16; k++) begin
      vecs[0].din[k] = W'(k);
      vecs[1].din[k] = W'(8'h10 + k);
      vecs[2].din[k] = W'(8'hF0 + k);
      vecs[3].din[k] = W'(15 - k);
    end
    vecs[0].dout = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                     8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    vecs[1].dout = '{8'h10, 8'h1D, 8'h1A, 8'h17, 8'h14, 8'h11, 8'h1E, 8'h1B,
                     8'h18, 8'h15, 8'h12, 8'h1F, 8'h1C, 8'h19, 8'h16, 8'h13};
    vecs[2].dout = '{8'hF0, 8'hFD, 8'hFA, 8'hF7, 8'hF4, 8'hF1, 8'hFE, 8'hFB,
                     8'hF8, 8'hF5, 8'hF2, 8'hFF, 8'hFC, 8'hF9, 8'hF6, 8'hF3};
    vecs[3].dout = '{8'h0F, 8'h02, 8'h05, 8'h08, 8'h0B, 8'h0E, 8'h01, 8'h04,
                     8'h07, 8'h0A, 8'h0D, 8'h00, 8'h03, 8'h06, 8'h09, 8'h0C};

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_m_last",  32'(bus.m_last),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    #1;

    // table vectors, back to back; first block also checks output latency
    total_waits = 0;
    for (int v = 0; v < 4; v++) begin
      expect_block(vecs[v].dout);
      for (int k = 0; k < 16; k++) begin
        push_byte(vecs[v].din[k], 0, waits);
        total_waits += waits;
        if (v == 0 && k == 14) check("latency_before", 32'(bus.m_valid), 32'd0);
        if (v == 0 && k == 15) begin
          check("latency_valid", 32'(bus.m_valid), 32'd1);
          check("latency_data",  32'(bus.m_data),  32'h00);
        end
      end
    end
    check("b2b_no_stall", 32'(total_waits), 32'd0);
    wait_drain();
    @(negedge clk);
    check("idle_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    #1;

    // backpressure: both banks fill, input blocks until block 0 drains
    ready_stall = 100;
    @(posedge clk);
    #1;
    expect_block(vecs[0].dout);
    expect_block(vecs[1].dout);
    expect_block(vecs[2].dout);
    total_waits = 0;
    for (int k = 0; k < 16; k++) begin
      push_byte(vecs[0].din[k], 0, waits);
      total_waits += waits;
    end
    for (int k = 0; k < 16; k++) begin
      push_byte(vecs[1].din[k], 0, waits);
      total_waits += waits;
    end
    check("fill_two_no_stall", 32'(total_waits), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_data  = vecs[2].din[0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_s_ready", 32'(bus.s_ready), 32'd0);
      check("full_m_data",  32'({bus.m_valid, bus.m_data}), 32'h100);
      @(posedge clk);
      #1;
    end
    ready_stall = 0;
    push_byte(vecs[2].din[0], 0, waits);
    check("ready_return_wait", 32'(waits), 32'd16);
    for (int k = 1; k < 16; k++) push_byte(vecs[2].din[k], 0, waits);
    wait_drain();

    // reset mid-block discards the partial block
    for (int k = 0; k < 7; k++) push_byte(W'(8'h50 + k), 0, waits);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_block(vecs[1].dout);
    for (int k = 0; k < 16; k++) begin
      push_byte(vecs[1].din[k], 0, waits);
      if (k == 8) check("midrst_no_stale", 32'(bus.m_valid), 32'd0);
    end
    wait_drain();

    // random data with stalls on both sides
    ready_stall = 30;
    for (int b = 0; b < 200; b++) begin
      for (int k = 0; k < 16; k++) rdin[k] = W'($urandom_range(255));
      for (int k = 0; k < 16; k++) rdout[k] = rdin[inv_tbl[k]];
      expect_block(rdout);
      for (int k = 0; k < 16; k++) push_byte(rdin[k], 30, waits);
    end
    ready_stall = 0;
    wait_drain();

`ifdef SHIFT_ROWS_FWD_MODE_EN
    begin
      logic [W-1:0] fdout [16];
      fdout = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
      expect_block(fdout);
      bus.fwd_mode = 1'b1;
      for (int k = 0; k < 16; k++) begin
        push_byte(vecs[0].din[k], 0, waits);
        bus.fwd_mode = 1'b0;
      end
      expect_block(vecs[0].din);
      for (int k = 0; k < 16; k++) begin
        bus.fwd_mode = (k != 0);
        push_byte(fdout[k], 0, waits);
      end
      bus.fwd_mode = 1'b0;
      wait_drain();
    end
`endif

    repeat (4) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
